// File: rtl/uart_pkg.sv
// Shared UART command definitions: default command width, field layout and
// the output-stage load selection used by the command queue.
package uart_pkg;

  localparam int CMD_W_DEF = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_BREAK = 4'hF
  } uart_op_e;

  // Command word layout as seen by the uart block.
  typedef struct packed {
    uart_op_e    opcode;
    logic [3:0]  addr;
    logic [7:0]  data;
  } uart_cmd_t;

  // What the queue's output register does on a given cycle.
  typedef enum logic [1:0] {
    OUT_HOLD,
    OUT_ARRAY,
    OUT_BYPASS,
    OUT_DRAIN
  } out_sel_e;

  function automatic uart_op_e cmd_opcode(input logic [CMD_W_DEF-1:0] word);
    uart_cmd_t c;
    c = uart_cmd_t'(word);
    return c.opcode;
  endfunction

endpackage

// File: rtl/uart_cmd_mem.sv
// Command storage array: one synchronous write port and one
// combinational read port.
module uart_cmd_mem #(
  parameter  int CMD_WIDTH = 16,
  parameter  int DEPTH     = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [CMD_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [CMD_WIDTH-1:0] rdata
);

  logic [CMD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_queue.sv
// Command queue in front of the uart: DEPTH-entry array plus a registered
// show-ahead output stage, with a sticky overflow flag for dropped writes.
module uart_cmd_queue
  import uart_pkg::*;
#(
  parameter  int CMD_WIDTH = CMD_W_DEF,
  parameter  int DEPTH     = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_WIDTH-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level,
  output logic [CMD_WIDTH-1:0] cmd_in,
  output logic                 cmd_vld,
  input  logic                 cmd_rdy,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          arr_cnt;
  logic                 arr_empty;
  logic                 push;
  logic                 pop;
  logic                 out_free;
  logic                 mem_we;
  logic [CMD_WIDTH-1:0] mem_rdata;
  out_sel_e             out_sel;

  assign full      = (level == (AW+1)'(DEPTH + 1));
  assign empty     = (level == '0);
  assign push      = wr_en & ~full;
  assign pop       = cmd_vld & cmd_rdy;
  assign out_free  = ~cmd_vld | pop;
  // Words in the array are everything counted by level except the output register.
  assign arr_cnt   = level - (AW+1)'(cmd_vld);
  assign arr_empty = (arr_cnt == '0);

  always_comb begin
    out_sel = OUT_HOLD;
    if (out_free) begin
      if (!arr_empty)  out_sel = OUT_ARRAY;
      else if (push)   out_sel = OUT_BYPASS;
      else             out_sel = OUT_DRAIN;
    end
  end

  assign mem_we = push & (out_sel != OUT_BYPASS);

  uart_cmd_mem #(
    .CMD_WIDTH (CMD_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_vld  <= 1'b0;
      cmd_in   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      case (out_sel)
        OUT_ARRAY: begin
          cmd_in  <= mem_rdata;
          cmd_vld <= 1'b1;
          rd_ptr  <= rd_ptr + 1'b1;
        end
        OUT_BYPASS: begin
          cmd_in  <= wr_data;
          cmd_vld <= 1'b1;
        end
        OUT_DRAIN: cmd_vld <= 1'b0;
        default:   ;
      endcase

      if (mem_we) wr_ptr <= wr_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase

      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

endmodule
